// File: rtl/window_generator.sv
// Streaming KxK sliding-window builder: K-1 line buffers feed a KxK shift window,
// and every fully-inside position is registered out under valid/ready handshaking.
module window_generator #(
    parameter int DATA_WIDTH   = 16,
    parameter int KERNEL_SIZE  = 5,
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [DATA_WIDTH-1:0]                       pixel_in,
    input  logic                                        pixel_valid,
    output logic                                        pixel_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window,
    output logic                                        window_valid,
    input  logic                                        window_ready,
    output logic                                        window_last
);

    localparam int K    = KERNEL_SIZE;
    localparam int TAPS = K * K;
    localparam int CW   = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] COL_EDGE = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_EDGE = RW'(K - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          emit;
    logic          frame_end;

    // line_buf[0] holds the oldest row (row-K+1), line_buf[K-2] the previous row
    logic [DATA_WIDTH-1:0] line_buf [K-1][IMAGE_WIDTH];
    logic [DATA_WIDTH-1:0] tap      [K];

    // Element r*K+c; packed index 0 sits in the least-significant slice
    logic [TAPS-1:0][DATA_WIDTH-1:0] win;
    logic [TAPS-1:0][DATA_WIDTH-1:0] win_next;
    logic [TAPS-1:0][DATA_WIDTH-1:0] win_out;

    assign pixel_ready = !window_valid || window_ready;
    assign accept      = pixel_valid && pixel_ready;
    assign emit        = accept && (row >= ROW_EDGE) && (col >= COL_EDGE);
    assign frame_end   = (row == ROW_LAST) && (col == COL_LAST);
    assign window      = win_out;

    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            tap[r] = line_buf[r][col];
        end
        tap[K-1] = pixel_in;
    end

    always_comb begin
        win_next = win;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_next[r*K+c] = win[r*K+c+1];
            end
            win_next[r*K+K-1] = tap[r];
        end
    end

    // Line-buffer storage is intentionally not reset; the first K-1 rows of a
    // frame overwrite every column before any window can be emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < K - 2; j++) begin
                line_buf[j][col] <= line_buf[j+1][col];
            end
            line_buf[K-2][col] <= pixel_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            win <= '0;
        end else if (accept) begin
            win <= win_next;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_valid <= 1'b0;
            window_last  <= 1'b0;
            win_out      <= '0;
        end else if (emit) begin
            window_valid <= 1'b1;
            window_last  <= frame_end;
            win_out      <= win_next;
        end else if (window_ready) begin
            window_valid <= 1'b0;
            window_last  <= 1'b0;
        end
    end

endmodule
